// File: rtl/ram_pg_pkg.sv
// Shared state type and fill-value helpers for the power-gated multi-port RAM.
// The fill-mode macros are guarded so that every file of the bundle may define them.
`ifndef RAM_RESET_ZERO
`define RAM_RESET_ZERO 0
`endif
`ifndef RAM_RESET_SEQ
`define RAM_RESET_SEQ 1
`endif

package ram_pg_pkg;

    typedef enum logic [1:0] {INIT, ON, OFF, WAKE} part_state_t;

    // Any RESET_VAL other than the two fill modes means "no fill".
    function automatic bit fill_enabled(input int reset_val);
        return (reset_val == `RAM_RESET_ZERO) || (reset_val == `RAM_RESET_SEQ);
    endfunction

    // Fill value for global entry idx; the caller truncates it to the data width.
    function automatic logic [63:0] fill(input int unsigned idx, input int reset_val,
                                         input int unsigned seq_start);
        if (reset_val == `RAM_RESET_SEQ) begin
            return 64'(seq_start) + 64'(idx);
        end
        return '0;
    endfunction

endpackage

// File: rtl/ram_pg_part_ctrl.sv
// Per-partition power sequencer: tracks gate/wake/re-init and drives the fill port.
// One instance per partition; the array itself lives in the top level.
module ram_pg_part_ctrl
    import ram_pg_pkg::*;
#(
    parameter int unsigned PART_DEPTH   = 16,
    parameter int unsigned WAKE_LAT     = 4,
    parameter int unsigned CNT_W        = 5,
    parameter bit          DO_FILL      = 1'b1,
    parameter bit          INIT_ON_WAKE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwr_gate_i,
    output logic             ready_o,
    output logic             fill_en_o,
    output logic [CNT_W-1:0] fill_idx_o,
    output logic             off_entry_o
);

    localparam logic [CNT_W-1:0] LastIdx    = CNT_W'(PART_DEPTH - 1);
    localparam logic [CNT_W-1:0] WakeInit   = CNT_W'(WAKE_LAT - 1);
    localparam part_state_t      ResetState = DO_FILL ? INIT : ON;
    localparam part_state_t      WakeTarget = (DO_FILL && INIT_ON_WAKE) ? INIT : ON;

    part_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ResetState;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gating wins over every other transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                if (pwr_gate_i) begin
                    state_d = OFF;
                end else if (cnt_q == LastIdx) begin
                    state_d = ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ON: begin
                if (pwr_gate_i) state_d = OFF;
            end
            OFF: begin
                if (!pwr_gate_i) begin
                    state_d = WAKE;
                    cnt_d   = WakeInit;
                end
            end
            WAKE: begin
                if (pwr_gate_i) begin
                    state_d = OFF;
                end else if (cnt_q == '0) begin
                    state_d = WakeTarget;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ResetState;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        ready_o     = (state_q == ON) && !pwr_gate_i;
        fill_en_o   = (state_q == INIT) && !pwr_gate_i && !reset;
        fill_idx_o  = cnt_q;
        off_entry_o = (state_q != OFF) && (state_d == OFF) && !reset;
    end

endmodule

// File: rtl/ram_pg_mpart.sv
// Multi-port register-file RAM split into independently power-gated partitions.
// Owns the array, read muxing with readiness masking, write arbitration and optional bypass.
`ifndef RAM_RESET_ZERO
`define RAM_RESET_ZERO 0
`endif
`ifndef RAM_RESET_SEQ
`define RAM_RESET_SEQ 1
`endif

module ram_pg_mpart
    import ram_pg_pkg::*;
#(
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned INDEX        = 6,
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned NUM_RD       = 2,
    parameter int unsigned NUM_WR       = 1,
    parameter int unsigned NUM_PART     = 4,
    parameter int unsigned WAKE_LAT     = 4,
    parameter int          RESET_VAL    = `RAM_RESET_ZERO,
    parameter int unsigned SEQ_START    = 0,
    parameter bit          INIT_ON_WAKE = 1'b1,
    parameter bit          BYPASS       = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_PART-1:0]     pwrGate_i,
    input  logic [NUM_RD*INDEX-1:0] addr_i,
    output logic [NUM_RD*WIDTH-1:0] data_o,
    output logic [NUM_RD-1:0]       dataValid_o,
    input  logic [NUM_WR-1:0]       we_i,
    input  logic [NUM_WR*INDEX-1:0] addrWr_i,
    input  logic [NUM_WR*WIDTH-1:0] data_i,
    output logic [NUM_WR-1:0]       wrDrop_o,
    output logic [NUM_PART-1:0]     partReady_o
);

    localparam int unsigned PartDepth = DEPTH / NUM_PART;
    localparam int unsigned PartW     = (NUM_PART > 1) ? $clog2(NUM_PART) : 1;
    localparam int unsigned MaxCnt    = (PartDepth > WAKE_LAT) ? PartDepth : WAKE_LAT;
    localparam int unsigned CntW      = $clog2(MaxCnt + 1);
    localparam bit          DoFill    = fill_enabled(RESET_VAL);
`ifdef SIM
    localparam bit          PoisonOff = 1'b1;
`else
    localparam bit          PoisonOff = 1'b0;
`endif

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic [NUM_PART-1:0] fill_en;
    logic [NUM_PART-1:0] off_entry;
    logic [CntW-1:0]     fill_idx [NUM_PART];
    logic [NUM_WR-1:0]   wr_commit;

    function automatic logic [PartW-1:0] part_of(input logic [INDEX-1:0] a);
        if (NUM_PART == 1) return '0;
        return a[INDEX-1 -: PartW];
    endfunction

    for (genvar p = 0; p < NUM_PART; p++) begin : g_part
        ram_pg_part_ctrl #(
            .PART_DEPTH  (PartDepth),
            .WAKE_LAT    (WAKE_LAT),
            .CNT_W       (CntW),
            .DO_FILL     (DoFill),
            .INIT_ON_WAKE(INIT_ON_WAKE)
        ) u_ctrl (
            .clk        (clk),
            .reset      (reset),
            .pwr_gate_i (pwrGate_i[p]),
            .ready_o    (partReady_o[p]),
            .fill_en_o  (fill_en[p]),
            .fill_idx_o (fill_idx[p]),
            .off_entry_o(off_entry[p])
        );
    end

    always_comb begin
        wr_commit = '0;
        wrDrop_o  = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (we_i[w] && !reset) begin
                if (partReady_o[part_of(addrWr_i[w*INDEX +: INDEX])]) wr_commit[w] = 1'b1;
                else                                                  wrDrop_o[w]  = 1'b1;
            end
        end
    end

    // Ascending port order lets the highest-indexed write port win a collision.
    always_comb begin
        int unsigned fidx;
        fidx  = 0;
        mem_d = mem_q;
        if (!reset) begin
            for (int p = 0; p < NUM_PART; p++) begin
                if (PoisonOff && off_entry[p]) begin
                    for (int i = 0; i < PartDepth; i++) mem_d[p*PartDepth + i] = 'x;
                end
                if (fill_en[p]) begin
                    fidx = p * PartDepth + int'(fill_idx[p]);
                    mem_d[INDEX'(fidx)] = WIDTH'(fill(fidx, RESET_VAL, SEQ_START));
                end
            end
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_commit[w]) mem_d[addrWr_i[w*INDEX +: INDEX]] = data_i[w*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        logic [INDEX-1:0] raddr;
        logic [WIDTH-1:0] rdata;
        raddr       = '0;
        rdata       = '0;
        data_o      = '0;
        dataValid_o = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            raddr = addr_i[r*INDEX +: INDEX];
            rdata = mem_q[raddr];
            if (BYPASS) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_commit[w] && (addrWr_i[w*INDEX +: INDEX] == raddr)) begin
                        rdata = data_i[w*WIDTH +: WIDTH];
                    end
                end
            end
            if (partReady_o[part_of(raddr)] && !reset) begin
                dataValid_o[r]             = 1'b1;
                data_o[r*WIDTH +: WIDTH]   = rdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_pg_mpart.sv
// Directed bench: two instances (zero fill / no bypass, sequential fill / bypass) share stimulus.
`ifndef RAM_RESET_ZERO
`define RAM_RESET_ZERO 0
`endif
`ifndef RAM_RESET_SEQ
`define RAM_RESET_SEQ 1
`endif

module tb_ram_pg_mpart;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  pwr_gate;
    logic [11:0] addr;
    logic [1:0]  we;
    logic [11:0] addr_wr;
    logic [63:0] wdata;

    logic [63:0] data_a, data_b;
    logic [1:0]  valid_a, valid_b, drop_a, drop_b;
    logic [3:0]  ready_a, ready_b;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    ram_pg_mpart #(
        .NUM_WR   (2),
        .RESET_VAL(`RAM_RESET_ZERO),
        .BYPASS   (1'b0)
    ) dut_a (
        .clk        (clk),
        .reset      (reset),
        .pwrGate_i  (pwr_gate),
        .addr_i     (addr),
        .data_o     (data_a),
        .dataValid_o(valid_a),
        .we_i       (we),
        .addrWr_i   (addr_wr),
        .data_i     (wdata),
        .wrDrop_o   (drop_a),
        .partReady_o(ready_a)
    );

    ram_pg_mpart #(
        .NUM_WR   (2),
        .RESET_VAL(`RAM_RESET_SEQ),
        .SEQ_START(8),
        .BYPASS   (1'b1)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .pwrGate_i  (pwr_gate),
        .addr_i     (addr),
        .data_o     (data_b),
        .dataValid_o(valid_b),
        .we_i       (we),
        .addrWr_i   (addr_wr),
        .data_i     (wdata),
        .wrDrop_o   (drop_b),
        .partReady_o(ready_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_rd(input int a0, input int a1);
        addr = {6'(a1), 6'(a0)};
    endtask

    task automatic set_wr(input logic [1:0] en, input int a0, input logic [31:0] d0,
                          input int a1, input logic [31:0] d1);
        we      = en;
        addr_wr = {6'(a1), 6'(a0)};
        wdata   = {d1, d0};
    endtask

    initial begin
        reset    = 1'b1;
        pwr_gate = 4'b0000;
        set_rd(5, 5);
        set_wr(2'b01, 5, 32'h1111_1111, 0, 0);
        #2;
        check("rst_ready_a", 64'(ready_a), 64'h0);
        check("rst_ready_b", 64'(ready_b), 64'h0);
        check("rst_valid_a", 64'(valid_a), 64'h0);
        check("rst_drop_a", 64'(drop_a), 64'h0);
        check("rst_data_b", data_b, 64'h0);
        ticks(2);
        set_wr(2'b00, 0, 0, 0, 0);
        reset = 1'b0;
        // Init fill: ready exactly after the 16th edge.
        ticks(15);
        check("init_ready_e15", 64'(ready_a), 64'h0);
        tick();
        check("init_ready_e16_a", 64'(ready_a), 64'hF);
        check("init_ready_e16_b", 64'(ready_b), 64'hF);
        for (int i = 0; i < 64; i++) begin
            set_rd(i, 63 - i);
            #1;
            check("fill_zero_a", data_a[31:0], 64'h0);
            check("fill_seq_b0", data_b[31:0], 64'(8 + i));
            check("fill_seq_b1", data_b[63:32], 64'(71 - i));
        end

        // Write-to-read latency and bypass.
        set_rd(5, 5);
        set_wr(2'b01, 5, 32'hDEAD_BEEF, 0, 0);
        #1;
        check("wr_same_cyc_a0", data_a[31:0], 64'h0);
        check("wr_same_cyc_a1", data_a[63:32], 64'h0);
        check("wr_bypass_b0", data_b[31:0], 64'hDEAD_BEEF);
        check("wr_bypass_b1", data_b[63:32], 64'hDEAD_BEEF);
        check("wr_nodrop", 64'(drop_a), 64'h0);
        tick();
        set_wr(2'b00, 0, 0, 0, 0);
        #1;
        check("wr_after_edge_a", data_a[31:0], 64'hDEAD_BEEF);
        check("wr_after_edge_a1", data_a[63:32], 64'hDEAD_BEEF);

        // Gate partition 1: writes there dropped, partition 0 unaffected.
        pwr_gate = 4'b0010;
        set_rd(20, 3);
        set_wr(2'b11, 20, 32'h0000_1234, 3, 32'h0000_0055);
        #1;
        check("gate_ready", 64'(ready_a), 64'hD);
        check("gate_drop_a", 64'(drop_a), 64'h1);
        check("gate_drop_b", 64'(drop_b), 64'h1);
        check("gate_valid_a", 64'(valid_a), 64'h2);
        check("gate_data0_a", data_a[31:0], 64'h0);
        check("gate_data0_b", data_b[31:0], 64'h0);
        check("gate_p0_old_a", data_a[63:32], 64'h0);
        check("gate_p0_byp_b", data_b[63:32], 64'h55);
        tick();
        set_wr(2'b00, 0, 0, 0, 0);
        #1;
        check("gate_p0_commit_a", data_a[63:32], 64'h55);

        // Release partition 1: ready after edge k+20, contents refilled.
        pwr_gate = 4'b0000;
        tick();
        ticks(19);
        check("wake1_e19", 64'(ready_a), 64'hD);
        tick();
        check("wake1_e20", 64'(ready_a), 64'hF);
        set_rd(20, 20);
        #1;
        check("wake1_refill_a", data_a[31:0], 64'h0);
        check("wake1_refill_b", data_b[31:0], 64'd28);
        check("wake1_valid_b", 64'(valid_b), 64'h3);

        // Two ports to one address: port 1 wins.
        set_rd(40, 40);
        set_wr(2'b11, 40, 32'h1, 40, 32'h2);
        #1;
        check("coll_byp_b", data_b[31:0], 64'h2);
        tick();
        set_wr(2'b00, 0, 0, 0, 0);
        #1;
        check("coll_a", data_a[31:0], 64'h2);
        check("coll_b", data_b[63:32], 64'h2);

        // Re-gate partition 2 during wake: sequence restarts in full.
        pwr_gate = 4'b0100;
        tick();
        pwr_gate = 4'b0000;
        ticks(3);
        pwr_gate = 4'b0100;
        #1;
        check("rewake_gated", 64'(ready_a), 64'hB);
        tick();
        pwr_gate = 4'b0000;
        tick();
        ticks(19);
        check("rewake_e19", 64'(ready_a), 64'hB);
        tick();
        check("rewake_e20", 64'(ready_a), 64'hF);
        #1;
        check("rewake_refill_a", data_a[31:0], 64'h0);
        check("rewake_refill_b", data_b[31:0], 64'd48);

        // Reset pulse mid-INIT of partition 3.
        pwr_gate = 4'b1000;
        tick();
        pwr_gate = 4'b0000;
        ticks(8);
        reset = 1'b1;
        set_rd(5, 63);
        #1;
        check("rst_mid_ready_a", 64'(ready_a), 64'h0);
        check("rst_mid_valid_b", 64'(valid_b), 64'h0);
        tick();
        reset = 1'b0;
        ticks(15);
        check("rst_mid_e15", 64'(ready_b), 64'h0);
        tick();
        check("rst_mid_e16", 64'(ready_b), 64'hF);
        #1;
        check("rst_refill_a", data_a[31:0], 64'h0);
        check("rst_refill_b5", data_b[31:0], 64'd13);
        check("rst_refill_b63", data_b[63:32], 64'd71);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_pg_mpart.md
# ram_pg_mpart

Parametrised multi-port register-file RAM with independently power-gated partitions and a per-partition wake/re-initialisation sequencer. It serves as the power-gated storage primitive for configurable structures such as the physical register file, issue queue payload and LSQ data, where lanes or segments are powered down. It has NUM_RD asynchronous read ports, NUM_WR write ports and NUM_PART contiguous partitions. Each partition reports when it holds defined contents, so consumers never act on power-gated data.

## Interface
Parameters:
- DEPTH, 64, total entries; must be a multiple of NUM_PART.
- INDEX, 6, address width; equals log2(DEPTH).
- WIDTH, 32, data bits per entry.
- NUM_RD, 2, read ports.
- NUM_WR, 1, write ports.
- NUM_PART, 4, power-gating partitions; power of two. PART_DEPTH = DEPTH/NUM_PART.
- WAKE_LAT, 4, cycles a partition waits after gate release before it may be written; must be ≥1.
- RESET_VAL, `RAM_RESET_ZERO, initial fill: `RAM_RESET_ZERO, `RAM_RESET_SEQ, or any other value for no fill.
- SEQ_START, 0, base for sequential fill; entry i gets (SEQ_START+i) truncated to WIDTH.
- INIT_ON_WAKE, 1, when 1 a partition re-runs the fill after wake; when 0 it returns to ON with undefined contents.
- BYPASS, 0, when 1 reads forward same-cycle write data.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- pwrGate_i  in  NUM_PART  per-partition gate request; 1 = power off.
- addr_i  in  NUM_RD*INDEX  read addresses, port r at [r*INDEX +: INDEX].
- data_o  out  NUM_RD*WIDTH  read data, port r at [r*WIDTH +: WIDTH].
- dataValid_o  out  NUM_RD  read r targets a ready partition.
- we_i  in  NUM_WR  write enables.
- addrWr_i  in  NUM_WR*INDEX  write addresses.
- data_i  in  NUM_WR*WIDTH  write data.
- wrDrop_o  out  NUM_WR  combinational: an enabled write targets a non-ready partition and is discarded.
- partReady_o  out  NUM_PART  partition is ON and not being gated.

## Operation
- The partition of an address is addr[INDEX-1 -: log2(NUM_PART)]. Partition p holds entries p*PART_DEPTH to (p+1)*PART_DEPTH-1.
- Each partition runs an FSM with states INIT, ON, OFF and WAKE, plus a pointer/counter cnt sized for max(PART_DEPTH, WAKE_LAT).
- Asynchronous reset: the FSM goes to INIT with cnt=0, or to ON when RESET_VAL means no fill. While reset is high, all outputs are 0 except partReady_o, which equals the reset state.
- INIT: each cycle writes the fill value to entry p*PART_DEPTH+cnt, then increments cnt. The edge that writes cnt==PART_DEPTH-1 moves the FSM to ON. If pwrGate_i[p] is 1, the FSM goes to OFF instead; gating takes priority.
- ON: reads and writes are permitted. If pwrGate_i[p] is 1, the FSM goes to OFF.
- OFF: under `SIM, every entry of the partition becomes X on entry; synthesis leaves the array unchanged. If pwrGate_i[p] is 0, the FSM goes to WAKE with cnt=WAKE_LAT-1.
- WAKE: cnt decrements each cycle. If pwrGate_i[p] is 1, the FSM returns to OFF. When cnt==0, the FSM goes to INIT with cnt=0 if INIT_ON_WAKE is 1, otherwise to ON.
- partReady_o[p] = (state==ON) & ~pwrGate_i[p].
- Reads are combinational. dataValid_o[r] = partReady_o of the partition addressed by read r. data_o[r] is forced to 0 when dataValid_o[r] is 0.
- Writes commit at the next rising edge only when partReady_o of the target partition is 1. Otherwise wrDrop_o[w] = 1.
- When several write ports target the same address, the highest-indexed port wins.
- INIT fill writes use internal ports and never conflict with external writes, because the partition is not ready during INIT.
- Bypass (BYPASS=1): a read whose address matches a committing write returns that write's data, with the highest-indexed port winning. With BYPASS=0, the read returns the old contents.

## Timing
- Read latency is 0 cycles (combinational). Write-to-read latency is 1 edge, or 0 cycles with bypass.
- After reset deasserts, partReady_o rises after PART_DEPTH edges (16 with defaults). With no fill, it rises immediately.
- pwrGate_i rising: partReady_o and dataValid_o fall in the same cycle, and writes in that cycle are dropped.
- pwrGate_i falling, first sampled low at edge k: WAKE spans edges k+1 to k+WAKE_LAT, then INIT spans PART_DEPTH edges. partReady_o rises after edge k+WAKE_LAT+PART_DEPTH, which is k+20 with defaults.
- Reset asserted mid-INIT, mid-WAKE or during writes: state, cnt and outputs update immediately. Any in-progress write does not commit.

## Structure
- Package ram_pg_pkg: part_state_t enum {INIT, ON, OFF, WAKE} and the fill-value function fill(idx).
- Sub-module ram_pg_part_ctrl: one per partition. It contains the FSM and cnt, and drives partReady_o, the fill enable and the fill index. The top level owns the array, read muxing, write arbitration and bypass.

## Test plan
- Reset, then wait 16 cycles → partReady_o steps 0000→1111 exactly on edge 16. All 64 entries read 0; with RESET_VAL=`RAM_RESET_SEQ and SEQ_START=8, entry 63 reads 71.
- Write 0xDEADBEEF to addr 5 on port 0, read addr 5 on both ports → old value in the same cycle (BYPASS=0) and 0xDEADBEEF after the edge. With BYPASS=1, 0xDEADBEEF in the same cycle.
- Assert pwrGate_i[1] and write addr 20 → wrDrop_o=1, read addr 20 gives dataValid_o=0 and data_o=0. Partition 0 reads and writes are unaffected.
- Release pwrGate_i[1] at edge k → partReady_o[1]=1 after edge k+20, and addr 20 reads 0 (INIT_ON_WAKE=1).
- Re-assert pwrGate_i[2] during WAKE cycle 2 → FSM returns to OFF and partReady_o[2] stays 0. After release, the full 20-cycle sequence restarts.
- Ports 0 and 1 (NUM_WR=2) write 0x1 and 0x2 to addr 40 → addr 40 reads 0x2. Pulse reset mid-INIT → partReady_o=0 at once, and INIT restarts from entry 0.
